// File: rtl/gru_seq_feeder.sv
// Ping-pong sequence buffer that replays buffered track vectors to the GRU x_t input
// at a fixed cadence of STEP_CYCLES per timestep, zero-padding short sequences to SEQ_LEN.
//   state | meaning
//   IDLE  | no full bank at rd_bank, outputs held at zero
//   PLAY  | replaying bank rd_bank, step/cyc track the cycle currently on the outputs
module gru_seq_feeder #(
  parameter int X_SIZE      = 6,
  parameter int SEQ_LEN     = 15,
  parameter int WIDTH       = 16,
  parameter int STEP_CYCLES = 19
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [WIDTH-1:0]    in_data [0:X_SIZE-1],
  input  logic                       in_last,
  output logic signed [WIDTH-1:0]    x_t [0:X_SIZE-1],
  output logic                       step_valid,
  output logic [$clog2(SEQ_LEN)-1:0] step_idx,
  output logic                       seq_first,
  output logic                       seq_last,
  output logic                       seq_done,
  output logic                       busy
);

  localparam int STEP_W = $clog2(SEQ_LEN);
  localparam int LEN_W  = $clog2(SEQ_LEN + 1);
  localparam int CYC_W  = $clog2(STEP_CYCLES);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SEQ_LEN - 1);
  localparam logic [CYC_W-1:0]  LAST_CYC  = CYC_W'(STEP_CYCLES - 1);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  mem [0:1][0:SEQ_LEN-1][0:X_SIZE-1];
  logic [1:0]        full;
  logic [LEN_W-1:0]  len [0:1];
  logic              wr_bank, rd_bank, rd_bank_nxt;
  logic [STEP_W-1:0] wr_idx, step, step_nxt;
  logic [CYC_W-1:0]  cyc, cyc_nxt;
  logic              accept, close, seq_end, play_nxt, pad_nxt;

  assign in_ready = !reset && !full[wr_bank];
  assign accept   = in_valid && in_ready;
  assign close    = accept && (in_last || wr_idx == LAST_STEP);
  assign seq_end  = (state == PLAY) && (cyc == LAST_CYC) && (step == LAST_STEP);

  // Storage is not reset; stale contents are never shown because len gates reads.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int j = 0; j < X_SIZE; j++) mem[wr_bank][wr_idx][j] <= in_data[j];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full    <= '0;
      wr_bank <= 1'b0;
      wr_idx  <= '0;
      len[0]  <= '0;
      len[1]  <= '0;
    end else begin
      if (accept) begin
        if (close) begin
          full[wr_bank] <= 1'b1;
          len[wr_bank]  <= LEN_W'(wr_idx) + LEN_W'(1);
          wr_idx        <= '0;
          wr_bank       <= !wr_bank;
        end else begin
          wr_idx <= wr_idx + 1'b1;
        end
      end
      // Write only touches a non-full bank, so this never collides with the set above.
      if (seq_end) full[rd_bank] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rd_bank <= 1'b0;
      step    <= '0;
      cyc     <= '0;
    end else begin
      state   <= state_nxt;
      rd_bank <= rd_bank_nxt;
      step    <= step_nxt;
      cyc     <= cyc_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    rd_bank_nxt = rd_bank;
    step_nxt    = step;
    cyc_nxt     = cyc;
    case (state)
      IDLE: begin
        if (full[rd_bank]) begin
          state_nxt = PLAY;
          step_nxt  = '0;
          cyc_nxt   = '0;
        end
      end
      PLAY: begin
        if (cyc != LAST_CYC) begin
          cyc_nxt = cyc + 1'b1;
        end else begin
          cyc_nxt = '0;
          if (step != LAST_STEP) begin
            step_nxt = step + 1'b1;
          end else begin
            step_nxt    = '0;
            rd_bank_nxt = !rd_bank;
            if (!full[!rd_bank]) state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they align with step/cyc.
  assign play_nxt = (state_nxt == PLAY);
  assign pad_nxt  = LEN_W'(step_nxt) >= len[rd_bank_nxt];

  always_ff @(posedge clk) begin
    if (reset) begin
      busy       <= 1'b0;
      step_valid <= 1'b0;
      seq_first  <= 1'b0;
      seq_last   <= 1'b0;
      seq_done   <= 1'b0;
      step_idx   <= '0;
      for (int j = 0; j < X_SIZE; j++) x_t[j] <= '0;
    end else begin
      busy       <= play_nxt;
      step_valid <= play_nxt && (cyc_nxt == '0);
      seq_first  <= play_nxt && (cyc_nxt == '0) && (step_nxt == '0);
      seq_last   <= play_nxt && (cyc_nxt == '0) && (step_nxt == LAST_STEP);
      seq_done   <= play_nxt && (cyc_nxt == LAST_CYC) && (step_nxt == LAST_STEP);
      step_idx   <= play_nxt ? step_nxt : '0;
      for (int j = 0; j < X_SIZE; j++)
        x_t[j] <= (play_nxt && !pad_nxt) ? mem[rd_bank_nxt][step_nxt][j] : '0;
    end
  end

endmodule

// File: tb/tb_gru_seq_feeder.sv
// Scoreboard bench for gru_seq_feeder: driver pushes expected timesteps on sequence close,
// a negedge monitor pops and compares on every step_valid.
module tb_gru_seq_feeder;
  localparam int XS = 6, SL = 15, W = 16, SC = 19;
  localparam int SSL = 3, SSC = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  logic                 in_valid, in_ready, in_last;
  logic signed [W-1:0]  in_data [0:XS-1];
  logic signed [W-1:0]  x_t [0:XS-1];
  logic                 step_valid, seq_first, seq_last, seq_done, busy;
  logic [$clog2(SL)-1:0] step_idx;

  logic                 s_in_valid, s_in_ready, s_in_last;
  logic signed [W-1:0]  s_in_data [0:XS-1];
  logic signed [W-1:0]  s_x_t [0:XS-1];
  logic                 s_step_valid, s_seq_first, s_seq_last, s_seq_done, s_busy;
  logic [$clog2(SSL)-1:0] s_step_idx;

  gru_seq_feeder #(.X_SIZE(XS), .SEQ_LEN(SL), .WIDTH(W), .STEP_CYCLES(SC)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .x_t(x_t), .step_valid(step_valid),
    .step_idx(step_idx), .seq_first(seq_first), .seq_last(seq_last),
    .seq_done(seq_done), .busy(busy));

  gru_seq_feeder #(.X_SIZE(XS), .SEQ_LEN(SSL), .WIDTH(W), .STEP_CYCLES(SSC)) dut_s (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .in_last(s_in_last), .x_t(s_x_t), .step_valid(s_step_valid),
    .step_idx(s_step_idx), .seq_first(s_seq_first), .seq_last(s_seq_last),
    .seq_done(s_seq_done), .busy(s_busy));

  logic [XS*W-1:0] xflat;
  always_comb begin
    xflat = '0;
    for (int j = 0; j < XS; j++) xflat[j*W +: W] = x_t[j];
  end

  int nvec = 0, nmis = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [XS*W-1:0] xv;
    logic [3:0]      idx;
    logic            first;
    logic            last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int first_q[$], done_q[$], last_q[$];
  int mon_step = -1;
  int last_sv_e = 0, cur_first_e = 0, sv_cnt = 0;
  logic [XS*W-1:0] held = '0;

  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      held     = '0;
      sv_cnt   = 0;
      mon_step = -1;
    end else begin
      if (step_valid) begin
        if (sb.size() == 0) begin
          nvec++;
          nmis++;
          $display("FAIL unexpected_step: step_valid with idx %0d, no step expected (t=%0t)", step_idx, $time);
        end else begin
          mon_e = sb.pop_front();
          chk("x_t", xflat, mon_e.xv);
          chk("step_idx", step_idx, mon_e.idx);
          chk("seq_first", seq_first, mon_e.first);
          chk("seq_last", seq_last, mon_e.last);
        end
        if (seq_first) begin
          first_q.push_back(ecnt);
          cur_first_e = ecnt;
          sv_cnt = 0;
        end else begin
          chk("step_spacing", ecnt - last_sv_e, SC);
        end
        if (seq_last) last_q.push_back(ecnt);
        sv_cnt++;
        last_sv_e = ecnt;
        held = xflat;
        mon_step = step_idx;
      end else if (busy) begin
        chk("x_t_hold", xflat, held);
      end
      if (seq_done) begin
        done_q.push_back(ecnt);
        chk("done_pos", ecnt - cur_first_e, SL*SC - 1);
        chk("steps_per_seq", sv_cnt, SL);
      end
    end
  end

  int s_sv_q[$], s_first_q[$], s_done_q[$], s_x0_q[$];
  always @(negedge clk) begin
    if (!reset) begin
      if (s_step_valid) begin
        s_sv_q.push_back(ecnt);
        s_x0_q.push_back(int'(s_x_t[0]));
      end
      if (s_seq_first) s_first_q.push_back(ecnt);
      if (s_seq_done) s_done_q.push_back(ecnt);
    end
  end

  function automatic logic [XS*W-1:0] vec(input int base, input int s);
    logic [XS*W-1:0] v;
    v = '0;
    for (int j = 0; j < XS; j++) v[j*W +: W] = W'(base + 16*s + j);
    return v;
  endfunction

  int stall_cnt = 0, acc_e = 0, first_acc = 0, last_acc = 0;

  // Entered just after a posedge; returns at the posedge that accepted the beat.
  task automatic beat(input logic [XS*W-1:0] v, input logic last);
    logic rdy;
    #1;
    in_valid = 1'b1;
    in_last  = last;
    for (int j = 0; j < XS; j++) in_data[j] = v[j*W +: W];
    rdy = 1'b0;
    for (int w = 0; w < 3000; w++) begin
      #1 rdy = in_ready;
      if (rdy) acc_e = ecnt + 1;
      else stall_cnt++;
      @(posedge clk);
      if (rdy) break;
      #1;
    end
    if (!rdy) begin
      nvec++;
      nmis++;
      $display("FAIL beat_timeout: in_ready stayed 0, required 1 within 3000 cycles");
    end
  endtask

  task automatic send_seq(input int n, input int base, input bit gaps);
    for (int s = 0; s < n; s++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        repeat (g) begin
          #1 in_valid = 1'b0;
          in_last = 1'b0;
          @(posedge clk);
        end
      end
      beat(vec(base, s), s == n - 1);
      if (s == 0) first_acc = acc_e;
    end
    last_acc = acc_e;
    for (int t = 0; t < SL; t++) begin
      exp_t e;
      e.xv    = (t < n) ? vec(base, t) : '0;
      e.idx   = 4'(t);
      e.first = (t == 0);
      e.last  = (t == SL - 1);
      sb.push_back(e);
    end
  endtask

  task automatic idle_in();
    #1 in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      nvec++;
      nmis++;
      $display("FAIL idle_timeout: %0d steps still pending, busy=%0b, required 0 and 0", sb.size(), busy);
    end
    @(posedge clk);
  endtask

  task automatic clear_logs();
    first_q.delete();
    done_q.delete();
    last_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lens [6];
    int s_a;
    int s_exp_x0 [6];
    lens = '{1, 7, 15, 3, 12, 9};
    s_exp_x0 = '{7, 8, 9, 42, 0, 0};
    reset = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    s_in_valid = 1'b0;
    s_in_last = 1'b0;
    for (int j = 0; j < XS; j++) begin
      in_data[j] = '0;
      s_in_data[j] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_step_valid", step_valid, 0);
    chk("rst_seq_done", seq_done, 0);
    chk("rst_step_idx", step_idx, 0);
    chk("rst_x_t", xflat, 0);
    reset = 1'b0;
    #1;
    chk("in_ready_after_rst", in_ready, 1);
    chk("s_in_ready_after_rst", s_in_ready, 1);
    @(posedge clk);

    // Single full sequence, absolute cycle positions relative to the first accept.
    clear_logs();
    send_seq(15, 0, 0);
    idle_in();
    wait_idle();
    chk("t1_nseq", done_q.size(), 1);
    chk("t1_seq_first_cycle", first_q[0] - first_acc + 1, 16);
    chk("t1_seq_last_cycle", last_q[0] - first_acc + 1, 282);
    chk("t1_seq_done_cycle", done_q[0] - first_acc + 1, 300);

    // Short sequence, zero padding checked by the scoreboard.
    clear_logs();
    send_seq(4, 256, 0);
    idle_in();
    wait_idle();
    chk("t2_nseq", done_q.size(), 1);
    chk("t2_latency", first_q[0] - last_acc, 1);

    // Three sequences streamed continuously.
    clear_logs();
    stall_cnt = 0;
    send_seq(15, 16'h0400, 0);
    send_seq(15, 16'h0800, 0);
    chk("t3_no_stall_two", stall_cnt, 0);
    send_seq(15, 16'h0C00, 0);
    idle_in();
    chk("t3_stalled", stall_cnt > 0, 1);
    chk("t3_seq3_accept", first_acc - done_q[0], 2);
    wait_idle();
    chk("t3_nseq", done_q.size(), 3);
    chk("t3_back_to_back", first_q[1] - done_q[0], 1);
    chk("t3_back_to_back2", first_q[2] - done_q[1], 1);

    // Random gaps, mixed lengths.
    clear_logs();
    for (int i = 0; i < 6; i++) send_seq(lens[i], 16'h1000 + 16'h100*i, 1);
    idle_in();
    wait_idle();
    chk("t4_nseq", done_q.size(), 6);

    // Reset at step 7 while the other bank is full.
    clear_logs();
    send_seq(15, 1000, 0);
    send_seq(15, 2000, 0);
    idle_in();
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 1000; i++) begin
        @(posedge clk);
        if (mon_step == 7) begin
          seen = 1'b1;
          break;
        end
      end
      chk("t5_reached_step7", seen, 1);
    end
    #1;
    chk("t5_in_ready_both_full", in_ready, 0);
    reset = 1'b1;
    #1;
    chk("t5_in_ready_in_reset", in_ready, 0);
    @(posedge clk);
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_step_valid", step_valid, 0);
    chk("t5_seq_first", seq_first, 0);
    chk("t5_seq_last", seq_last, 0);
    chk("t5_seq_done", seq_done, 0);
    chk("t5_step_idx", step_idx, 0);
    chk("t5_x_t", xflat, 0);
    reset = 1'b0;
    #1;
    chk("t5_in_ready_after", in_ready, 1);
    @(posedge clk);
    clear_logs();
    send_seq(15, 3000, 0);
    idle_in();
    wait_idle();
    chk("t5_nseq", done_q.size(), 1);
    chk("t5_latency", first_q[0] - last_acc, 1);

    // Small instance: SEQ_LEN=3, STEP_CYCLES=2.
    s_a = 0;
    for (int s = 0; s < 4; s++) begin
      #1;
      s_in_valid = 1'b1;
      s_in_last  = (s >= 2);
      for (int j = 0; j < XS; j++) s_in_data[j] = W'(s_exp_x0[s] + j);
      #1;
      chk("s_in_ready", s_in_ready, 1);
      if (s == 0) s_a = ecnt + 1;
      @(posedge clk);
    end
    #1 s_in_valid = 1'b0;
    s_in_last = 1'b0;
    repeat (30) @(posedge clk);
    chk("s_nsteps", s_sv_q.size(), 6);
    chk("s_latency", s_first_q[0] - s_a, 3);
    chk("s_spacing1", s_sv_q[1] - s_sv_q[0], SSC);
    chk("s_spacing2", s_sv_q[2] - s_sv_q[1], SSC);
    chk("s_done_after_first", s_done_q[0] - s_first_q[0], SSL*SSC - 1);
    chk("s_back_to_back", s_first_q[1] - s_done_q[0], 1);
    for (int k = 0; k < 6; k++) chk("s_x_t0", s_x0_q[k], s_exp_x0[k]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
